// File: rtl/wide_add_seq_pkg.sv
// wide_add_seq_pkg: shared state encoding and derived widths for the wide adder sequencer
package wide_add_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int WIDTH_DEF = 4;
   localparam int NSLICES_DEF = 4;
   localparam int W_DEF = WIDTH_DEF * NSLICES_DEF;
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/wide_add_seq_if.sv
// wide_add_seq_if: start/done request bus between a requester and the sequencer
interface wide_add_seq_if import wide_add_seq_pkg::*; #(parameter int W = W_DEF);
   logic start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic cin;
   logic busy;
   logic done;
   logic [W-1:0] s;
   logic cout;
   modport master (output start, a, b, cin, input busy, done, s, cout);
   modport slave (input start, a, b, cin, output busy, done, s, cout);
endinterface

// File: rtl/wide_add_seq_adder.sv
// adder: registered WIDTH-bit slice adder; deliberately has no reset
module adder #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);
   always_ff @(posedge clk)
      {cout, s} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: NSLICES*WIDTH-bit addition rippled LSB-first through one registered slice adder
module wide_add_seq import wide_add_seq_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NSLICES = NSLICES_DEF
) (
   input logic clk,
   input logic rst,
   wide_add_seq_if.slave bus
);
   localparam int W = WIDTH * NSLICES;
   localparam int IW = idx_w(NSLICES);
   state_t state;
   logic [IW-1:0] idx, cidx;
   logic first, cin_r, cout_r, busy_r, done_r;
   logic [W-1:0] a_r, b_r, s_r;
   logic [WIDTH-1:0] add_a, add_b, add_s;
   logic add_cin, add_cout, run;
   assign run = state == RUN;
   // first RUN cycle seeds the ripple with the latched carry, later ones chain the adder's carry
   assign add_a = run ? a_r[idx*WIDTH +: WIDTH] : '0;
   assign add_b = run ? b_r[idx*WIDTH +: WIDTH] : '0;
   assign add_cin = run ? (first ? cin_r : add_cout) : 1'b0;
   adder #(.WIDTH(WIDTH)) u_add (
      .clk(clk), .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .cout(add_cout)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         cidx <= '0;
         first <= 1'b0;
         a_r <= '0;
         b_r <= '0;
         cin_r <= 1'b0;
         s_r <= '0;
         cout_r <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (!run) begin
         done_r <= 1'b0;
         if (bus.start) begin
            state <= RUN;
            a_r <= bus.a;
            b_r <= bus.b;
            cin_r <= bus.cin;
            s_r <= '0;
            cout_r <= 1'b0;
            idx <= '0;
            first <= 1'b1;
            busy_r <= 1'b1;
         end else
            state <= IDLE;
      end else begin
         // cidx trails idx by one cycle: it names the slice the adder is presenting now
         idx <= idx == IW'(NSLICES - 1) ? idx : idx + 1'b1;
         cidx <= idx;
         first <= 1'b0;
         if (!first) begin
            s_r[cidx*WIDTH +: WIDTH] <= add_s;
            if (cidx == IW'(NSLICES - 1)) begin
               cout_r <= add_cout;
               state <= DONE;
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.s = s_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: directed checks of the wide adder sequencer at default parameters
module tb_wide_add_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int lat, n;
   wide_add_seq_if #(.W(16)) bus ();
   wide_add_seq #(.WIDTH(4), .NSLICES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [15:0] av, input logic [15:0] bv, input logic c);
      bus.start = 1'b1;
      bus.a = av;
      bus.b = bv;
      bus.cin = c;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 99;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic go(input logic [15:0] av, input logic [15:0] bv, input logic c, output int cyc);
      present(av, bv, c);
      tick();
      bus.start = 1'b0;
      wait_done(cyc);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      tick();
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.cout, bus.s} !== 19'd0) begin
         errors++;
         $display("FAIL reset busy=%b done=%b cout=%b s=%h want all 0", bus.busy, bus.done, bus.cout, bus.s);
      end
      present(16'h1, 16'h1, 1'b0);
      tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_vs_start busy=%b want 0", bus.busy);
      end
      bus.start = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      present(16'h1234, 16'h4321, 1'b0);
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy busy=%b done=%b want 1 0", bus.busy, bus.done);
      end
      wait_done(lat);
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL basic_latency got %0d want 5", lat);
      end
      checks++;
      if (bus.s !== 16'h5555 || bus.cout !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_sum s=%h cout=%b busy=%b want 5555 0 0", bus.s, bus.cout, bus.busy);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.s !== 16'h5555) begin
         errors++;
         $display("FAIL basic_hold done=%b s=%h want 0 5555", bus.done, bus.s);
      end
   endtask

   task automatic test_ripple();
      go(16'hFFFF, 16'h0001, 1'b0, lat);
      checks++;
      if (bus.s !== 16'h0000 || bus.cout !== 1'b1 || lat !== 5) begin
         errors++;
         $display("FAIL ripple_b s=%h cout=%b lat=%0d want 0000 1 5", bus.s, bus.cout, lat);
      end
      tick();
      go(16'hFFFF, 16'h0000, 1'b1, lat);
      checks++;
      if (bus.s !== 16'h0000 || bus.cout !== 1'b1 || lat !== 5) begin
         errors++;
         $display("FAIL ripple_cin s=%h cout=%b lat=%0d want 0000 1 5", bus.s, bus.cout, lat);
      end
      tick();
      go(16'h9ABC, 16'h7654, 1'b1, lat);
      checks++;
      if (bus.s !== 16'h1111 || bus.cout !== 1'b1) begin
         errors++;
         $display("FAIL mixed s=%h cout=%b want 1111 1", bus.s, bus.cout);
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      present(16'h0001, 16'h0001, 1'b0);
      tick();
      bus.start = 1'b0;
      tick();
      present(16'hAAAA, 16'h5555, 1'b1);
      tick();
      bus.start = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done) begin
            n++;
            checks++;
            if (bus.s !== 16'h0002 || bus.cout !== 1'b0) begin
               errors++;
               $display("FAIL ignore_sum s=%h cout=%b want 0002 0", bus.s, bus.cout);
            end
         end
         tick();
      end
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL ignore_dones got %0d want 1", n);
      end
   endtask

   task automatic test_back_to_back();
      present(16'h00FF, 16'h0001, 1'b0);
      tick();
      wait_done(lat);
      checks++;
      if (bus.s !== 16'h0100 || bus.cout !== 1'b0 || lat !== 5) begin
         errors++;
         $display("FAIL b2b_first s=%h cout=%b lat=%0d want 0100 0 5", bus.s, bus.cout, lat);
      end
      bus.a = 16'h8000;
      bus.b = 16'h8000;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.s !== 16'h0000) begin
         errors++;
         $display("FAIL b2b_accept busy=%b s=%h want 1 0000", bus.busy, bus.s);
      end
      wait_done(lat);
      checks++;
      if (bus.s !== 16'h0000 || bus.cout !== 1'b1 || lat !== 5) begin
         errors++;
         $display("FAIL b2b_second s=%h cout=%b lat=%0d want 0000 1 5", bus.s, bus.cout, lat);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      present(16'h1111, 16'h2222, 1'b0);
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 16'h0000) begin
         errors++;
         $display("FAIL midrst busy=%b done=%b s=%h want 0 0 0000", bus.busy, bus.done, bus.s);
      end
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.done) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL midrst_nodone got %0d dones want 0", n);
      end
      go(16'h0003, 16'h0004, 1'b0, lat);
      checks++;
      if (bus.s !== 16'h0007 || bus.cout !== 1'b0 || lat !== 5) begin
         errors++;
         $display("FAIL midrst_next s=%h cout=%b lat=%0d want 0007 0 5", bus.s, bus.cout, lat);
      end
      tick();
   endtask

   task automatic test_stale();
      present(16'hFFFF, 16'hFFFF, 1'b1);
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      go(16'h0000, 16'h0000, 1'b0, lat);
      checks++;
      if (bus.s !== 16'h0000 || bus.cout !== 1'b0 || lat !== 5) begin
         errors++;
         $display("FAIL stale s=%h cout=%b lat=%0d want 0000 0 5", bus.s, bus.cout, lat);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ripple();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_stale();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
